// File: rtl/sample_rom_player.sv
// Sample ROM player: address counter, prefetch FSM over a req/ack port, and DAC output.
// Optional low-pass audio filter enabled by defining SAMPLE_PLAYER_LPF_EN.
module sample_rom_player #(
  parameter int ROM_AW = 21,
  parameter int SHIFT  = 5
) (
  input  logic              CLK_32M,
  input  logic              reset,
  input  logic              pause,
  input  logic [1:0]        sample_addr_wr,
  input  logic [15:0]       sample_addr,
  input  logic              sample_inc,
  input  logic [7:0]        sample_out,
  output logic [7:0]        sample_in,
  output logic              sample_valid,
  output logic              rom_req,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic              rom_ack,
  input  logic [7:0]        rom_data,
  output logic [15:0]       audio_out,
  output logic              fsm_state
);

  // ROM port handshake: rom_req is a level held with rom_addr stable until a
  // single-cycle rom_ack; rom_data is only meaningful in the rom_ack cycle.
  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

  localparam int HW = ROM_AW - SHIFT - 8;

  state_t            state;
  logic [ROM_AW-1:0] counter;
  logic [ROM_AW-1:0] cnt_load;
  logic [ROM_AW-1:0] cnt_next;
  logic              cnt_change;
  logic              dirty;

  assign fsm_state = state;

  // Load is applied first so a same-cycle increment lands on the loaded value.
  always_comb begin
    cnt_load = counter;
    if (sample_addr_wr[0]) begin
      cnt_load[SHIFT+7:SHIFT] = sample_addr[7:0];
      cnt_load[SHIFT-1:0]     = '0;
    end
    if (sample_addr_wr[1]) begin
      cnt_load[ROM_AW-1:SHIFT+8] = HW'(sample_addr[15:8]);
    end
    cnt_next   = cnt_load + ROM_AW'(sample_inc);
    cnt_change = (sample_addr_wr != 2'b00) || sample_inc;
  end

  always_ff @(posedge CLK_32M) begin
    if (reset) begin
      state        <= S_IDLE;
      counter      <= '0;
      dirty        <= 1'b1;
      rom_req      <= 1'b0;
      rom_addr     <= '0;
      sample_in    <= 8'h80;
      sample_valid <= 1'b0;
    end else begin
      if (cnt_change) counter <= cnt_next;
      case (state)
        S_IDLE: begin
          if (dirty && !pause) begin
            rom_addr <= counter;
            rom_req  <= 1'b1;
            dirty    <= 1'b0;
            state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (rom_ack) begin
            rom_req <= 1'b0;
            state   <= S_IDLE;
            // Data belongs to rom_addr; drop it if the counter moved meanwhile.
            if (!dirty && !cnt_change) begin
              sample_in    <= rom_data;
              sample_valid <= 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
      if (cnt_change) begin
        dirty        <= 1'b1;
        sample_valid <= 1'b0;
      end
    end
  end

`ifdef SAMPLE_PLAYER_LPF_EN
  logic [15:0]        dac_val;
  logic [5:0]         tick;
  logic signed [17:0] acc;
  logic signed [17:0] d_ext;
  logic signed [17:0] diff;

  always_comb begin
    d_ext = {{2{dac_val[15]}}, dac_val};
    diff  = d_ext - acc;
  end

  always_ff @(posedge CLK_32M) begin
    if (reset) begin
      dac_val <= '0;
      tick    <= '0;
      acc     <= '0;
    end else begin
      if (sample_inc) dac_val <= {sample_out ^ 8'h80, 8'h00};
      if (!pause) begin
        tick <= tick + 6'd1;
        if (tick == 6'd63) acc <= acc + (diff >>> 3);
      end
    end
  end

  assign audio_out = acc[15:0];
`else
  always_ff @(posedge CLK_32M) begin
    if (reset) begin
      audio_out <= '0;
    end else if (sample_inc) begin
      audio_out <= {sample_out ^ 8'h80, 8'h00};
    end
  end
`endif

endmodule

// File: tb/tb_sample_rom_player.sv
// Directed plus randomized bench for sample_rom_player with an arithmetic
// address/audio model and an auto-acking ROM responder (rom_data = addr[7:0]).
`timescale 1ns/1ps
module tb_sample_rom_player;
  localparam int AW = 21;
  localparam int SH = 5;
  localparam longint BASE     = longint'(1) << SH;
  localparam longint LOW_SPAN = BASE * 256;
  localparam longint MODV     = longint'(1) << AW;

  logic          CLK_32M = 1'b0;
  logic          reset;
  logic          pause;
  logic [1:0]    sample_addr_wr;
  logic [15:0]   sample_addr;
  logic          sample_inc;
  logic [7:0]    sample_out;
  logic [7:0]    sample_in;
  logic          sample_valid;
  logic          rom_req;
  logic [AW-1:0] rom_addr;
  logic          rom_ack;
  logic [7:0]    rom_data;
  logic [15:0]   audio_out;
  logic          fsm_state;

  sample_rom_player #(.ROM_AW(AW), .SHIFT(SH)) dut (
    .CLK_32M(CLK_32M), .reset(reset), .pause(pause),
    .sample_addr_wr(sample_addr_wr), .sample_addr(sample_addr),
    .sample_inc(sample_inc), .sample_out(sample_out),
    .sample_in(sample_in), .sample_valid(sample_valid),
    .rom_req(rom_req), .rom_addr(rom_addr), .rom_ack(rom_ack),
    .rom_data(rom_data), .audio_out(audio_out), .fsm_state(fsm_state)
  );

  // Clock / reset block
  always #5 CLK_32M = ~CLK_32M;

  int            n_tests = 0;
  int            n_fail  = 0;
  logic [7:0]    exp_q[$];
  longint        m_addr  = 0;
  logic [15:0]   m_audio = '0;
  int            ack_delay = 3;
  int            req_count = 0;
  logic [AW-1:0] last_req  = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ROM responder: acks each request ack_delay cycles after it appears.
  initial begin
    int            wait_cnt;
    logic          hold;
    logic [AW-1:0] held;
    rom_ack = 1'b0; rom_data = '0; wait_cnt = 0; hold = 1'b0; held = '0;
    forever begin
      @(negedge CLK_32M);
      rom_ack = 1'b0;
      if (rom_req) begin
        if (!hold) begin
          req_count++;
          last_req = rom_addr;
          held     = rom_addr;
          hold     = 1'b1;
          wait_cnt = 0;
        end else begin
          check("rom_addr_stable", 32'(rom_addr), 32'(held));
        end
        wait_cnt++;
        if (wait_cnt >= ack_delay) begin
          rom_ack  = 1'b1;
          rom_data = held[7:0];
          hold     = 1'b0;
        end
      end else begin
        hold = 1'b0;
      end
    end
  end

  task automatic tick();
    @(negedge CLK_32M);
    #1;
  endtask

  // Driver: one cycle of loads and/or increment, with the model updated alongside.
  task automatic do_op(input logic [1:0] wr, input logic [15:0] val,
                       input logic inc, input logic [7:0] out);
    sample_addr_wr = wr; sample_addr = val; sample_inc = inc; sample_out = out;
    tick();
    sample_addr_wr = 2'b00; sample_inc = 1'b0;
    if (wr[0]) m_addr = (m_addr / LOW_SPAN) * LOW_SPAN + longint'(val[7:0]) * BASE;
    if (wr[1]) m_addr = (m_addr % LOW_SPAN) + (longint'(val[15:8]) * LOW_SPAN) % MODV;
    if (inc) begin
      m_addr  = (m_addr + 1) % MODV;
      m_audio = {out ^ 8'h80, 8'h00};
    end
    check("valid_drop", 32'(sample_valid), 32'd0);
`ifndef SAMPLE_PLAYER_LPF_EN
    if (inc) check("audio", 32'(audio_out), 32'(m_audio));
`endif
  endtask

  // Scoreboard: wait for the prefetch to land and compare against the model.
  task automatic settle(input string tag);
    int i;
    exp_q.push_back(8'(m_addr % 256));
    for (i = 0; i < 300 && !sample_valid; i++) tick();
    check({tag, "_timeout"}, 32'(sample_valid), 32'd1);
    check({tag, "_data"}, 32'(sample_in), 32'(exp_q.pop_front()));
    check({tag, "_addr"}, 32'(last_req), 32'(m_addr));
  endtask

  initial begin
    int            rc0;
    logic [7:0]    outs[3];
    logic [15:0]   auds[3];
    logic [1:0]    wr;
    logic          inc;
    outs[0] = 8'hFF; outs[1] = 8'h00; outs[2] = 8'h80;
    auds[0] = 16'h7F00; auds[1] = 16'h8000; auds[2] = 16'h0000;
    reset = 1'b1; pause = 1'b0; sample_addr_wr = '0; sample_addr = '0;
    sample_inc = 1'b0; sample_out = 8'h80;
    tick(); tick();
    check("rst_sample_in", 32'(sample_in), 32'h80);
    check("rst_valid", 32'(sample_valid), 32'd0);
    check("rst_req", 32'(rom_req), 32'd0);
    check("rst_rom_addr", 32'(rom_addr), 32'd0);
    check("rst_audio", 32'(audio_out), 32'd0);
    reset = 1'b0;
    tick();
    check("boot_req", 32'(rom_req), 32'd1);
    check("boot_rom_addr", 32'(rom_addr), 32'd0);
    settle("boot");
    check("boot_audio", 32'(audio_out), 32'd0);

    // Two-step address load
    do_op(2'b01, 16'h0012, 1'b0, 8'h80);
    do_op(2'b10, 16'h3400, 1'b0, 8'h80);
    settle("load");
    check("load_const", 32'(last_req), 32'h068240);

    // DAC increments
    for (int k = 0; k < 3; k++) begin
      do_op(2'b00, 16'h0000, 1'b1, outs[k]);
`ifndef SAMPLE_PLAYER_LPF_EN
      check("dac_const", 32'(audio_out), 32'(auds[k]));
`endif
      settle("inc");
    end
    check("inc_final", 32'(sample_in), 32'h43);

    // Address change while a fetch is outstanding
    ack_delay = 10;
    rc0 = req_count;
    do_op(2'b01, 16'h0055, 1'b0, 8'h80);
    tick(); tick(); tick();
    check("wait_req", 32'(rom_req), 32'd1);
    do_op(2'b01, 16'h0066, 1'b0, 8'h80);
    settle("stale");
    check("stale_reqs", 32'(req_count - rc0), 32'd2);

    // Wrap from all-ones
    ack_delay = 3;
    do_op(2'b11, 16'hFFFF, 1'b0, 8'h80);
    for (int k = 0; k < 31; k++) do_op(2'b00, 16'h0000, 1'b1, 8'($urandom_range(0, 255)));
    settle("top");
    check("top_const", 32'(last_req), 32'h1FFFFF);
    do_op(2'b00, 16'h0000, 1'b1, 8'h80);
    settle("wrap");
    check("wrap_const", 32'(last_req), 32'd0);

    // Pause holds off fetch issue
    pause = 1'b1;
    rc0 = req_count;
    do_op(2'b01, 16'($urandom_range(0, 255)), 1'b1, 8'h80);
    for (int k = 0; k < 20; k++) begin
      check("pause_no_req", 32'(rom_req), 32'd0);
      tick();
    end
    pause = 1'b0;
    settle("pause");
    check("pause_one_req", 32'(req_count - rc0), 32'd1);

    // Randomized loads/increments against the model
    for (int k = 0; k < 40; k++) begin
      ack_delay = $urandom_range(1, 6);
      wr  = 2'($urandom_range(0, 3));
      inc = 1'($urandom_range(0, 1));
      if (wr == 2'b00) inc = 1'b1;
      pause = ($urandom_range(0, 3) == 0);
      do_op(wr, 16'($urandom), inc, 8'($urandom_range(0, 255)));
      pause = 1'b0;
      if ($urandom_range(0, 2) == 0) settle("rand");
    end
    settle("rand_end");

    // Reset in the middle of a fetch
    ack_delay = 50;
    do_op(2'b10, 16'($urandom), 1'b0, 8'h80);
    tick(); tick();
    check("mid_req", 32'(rom_req), 32'd1);
    reset = 1'b1;
    tick();
    check("mid_rst_req", 32'(rom_req), 32'd0);
    check("mid_rst_valid", 32'(sample_valid), 32'd0);
    check("mid_rst_in", 32'(sample_in), 32'h80);
    check("mid_rst_audio", 32'(audio_out), 32'd0);
    reset = 1'b0; m_addr = 0; m_audio = '0; ack_delay = 3;
    settle("post_rst");

`ifdef SAMPLE_PLAYER_LPF_EN
    begin
      int prev;
      do_op(2'b00, 16'h0000, 1'b1, 8'hFF);
      prev = $signed(audio_out);
      for (int k = 0; k < 41 * 64; k++) begin
        tick();
        check("lpf_monotonic", 32'($signed(audio_out) >= prev), 32'd1);
        prev = $signed(audio_out);
      end
      check("lpf_near", 32'(prev >= 31853 && prev <= 32512), 32'd1);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
